button_event_io: RTL

//  Bus-mapped push-button peripheral. Replaces ad-hoc debounce logic at system top.

---
 rtl/button_event_if.sv | 27 ++
 rtl/button_event_io.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/button_event_if.sv
// Processor-side bus signals of the push-button peripheral, except the shared
// tristate data bus, which stays a plain inout port on the peripheral.
//   bus_addr             processor address
//   bus_we               write enable
//   bus_interrupt_raise  interrupt request to the processor
//   bus_interrupt_ack    one-cycle acknowledge from the processor
// master: processor side, slave: peripheral side.
interface button_event_if;
  logic [7:0] bus_addr;
  logic       bus_we;
  logic       bus_interrupt_raise;
  logic       bus_interrupt_ack;

  modport master (
    output bus_addr,
    output bus_we,
    output bus_interrupt_ack,
    input  bus_interrupt_raise
  );

  modport slave (
    input  bus_addr,
    input  bus_we,
    input  bus_interrupt_ack,
    output bus_interrupt_raise
  );
endinterface

// File: rtl/button_event_io.sv
// Bus-mapped push-button peripheral.
// Synchronises and debounces NUM_BTN raw buttons, latches press/release events
// in a W1C flag register and raises an edge-triggered interrupt with raise/ack
// handshake.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   btn_in     raw (asynchronous) button pins
//   bus_data   8-bit tristate processor data bus
//   bus        address / write enable / interrupt raise+ack (slave modport)
//   btn_state  debounced button levels
// Register window BASE_ADDR+0..3:
//   +0 R     debounced levels
//   +1 R/W1C flags: [3:0] press, [7:4] release
//   +2 R/W   interrupt mask, same layout as flags
//   +3 R     ID byte 8'h42
module button_event_io #(
  parameter logic [7:0]  BASE_ADDR       = 8'hE0,
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  inout  wire  [7:0]         bus_data,
  button_event_if.slave      bus,
  output logic [NUM_BTN-1:0] btn_state
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       BtnMask = 4'((1 << NUM_BTN) - 1);
  localparam logic [7:0]       IdByte  = 8'h42;

  typedef enum logic {StIdle = 1'b0, StRaised = 1'b1} state_e;

  logic [NUM_BTN-1:0]            sync1_q, sync2_q;
  logic [NUM_BTN-1:0]            stable_q, stable_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]                    flags_q, flags_d;
  logic [7:0]                    mask_q, mask_d;
  logic [7:0]                    new_events;
  logic                          evt_q, evt_d;
  state_e                        state_q, state_d;
  logic                          rd_en_q, rd_en_d;
  logic [7:0]                    rd_data_q, rd_mux;
  logic [7:0]                    offset;
  logic                          in_window, wr_flags, wr_mask;
  logic [7:0]                    clr;

  // Offset arithmetic wraps, so the window works for any base alignment.
  assign offset    = bus.bus_addr - BASE_ADDR;
  assign in_window = (offset[7:2] == 6'd0);
  assign wr_flags  = bus.bus_we && in_window && (offset[1:0] == 2'd1);
  assign wr_mask   = bus.bus_we && in_window && (offset[1:0] == 2'd2);
  assign rd_en_d   = in_window && !bus.bus_we;

  // Debounce: a level differing from stable for DEBOUNCE_CYCLES samples is adopted.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    new_events = {4'(stable_q & ~stable_d), 4'(stable_d & ~stable_q)};
    clr        = wr_flags ? bus_data : 8'h00;
    // Setting after clearing makes a coincident event win over W1C.
    flags_d    = ((flags_q & ~clr) | new_events) & {BtnMask, BtnMask};
    mask_d     = wr_mask ? bus_data : mask_q;
    evt_d      = |(new_events & mask_q);
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (offset[1:0])
      2'd0: rd_mux = 8'(stable_q);
      2'd1: rd_mux = flags_q;
      2'd2: rd_mux = mask_q;
      2'd3: rd_mux = IdByte;
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      flags_q   <= 8'h00;
      mask_q    <= 8'h00;
      evt_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      evt_q     <= evt_d;
      rd_en_q   <= rd_en_d;
      rd_data_q <= rd_mux;
    end
  end

  // Interrupt FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Interrupt FSM: next state. An enabled event landing now or one edge ago
  // keeps the request up even if ack is sampled on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (evt_q) state_d = StRaised;
      end
      StRaised: begin
        if (bus.bus_interrupt_ack && !evt_q && !evt_d) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Interrupt FSM: outputs.
  always_comb begin
    bus.bus_interrupt_raise = (state_q == StRaised);
  end

  assign btn_state = stable_q;
  assign bus_data  = rd_en_q ? rd_data_q : 8'hzz;

endmodule
